// File: rtl/mem_dump_reader.sv
// mem_dump_reader: reads a range of 32-bit words from a data memory and
// streams each word out as four bytes through a handshaked UART transmitter.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for start; range captured on the accepted start
// S_ISSUE    | address is stable, memory returns data on the falling edge
// S_CAPTURE  | read data registered into the word buffer, byte_idx cleared
// S_SEND     | waiting for tx_busy=0, then launches one byte with tx_start
// S_WAIT_ACK | waiting for the transmitter to raise tx_busy
// S_WAIT_TX  | waiting for the transmitter to finish the byte
// S_NEXT     | last word done -> S_DONE, else advance address (wrapping)
// S_DONE     | one-cycle done pulse
module mem_dump_reader #(
  parameter int ADDR_W    = 10,
  parameter int MSB_FIRST = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  input  logic [31:0]       mem_data_read,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_CAPTURE, S_SEND, S_WAIT_ACK, S_WAIT_TX, S_NEXT, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic [1:0]        lane;
  logic [7:0]        sel_byte;

  // Byte lane picked from the word buffer for the current byte_idx.
  always_comb begin
    lane     = (MSB_FIRST != 0) ? (2'd3 - byte_idx_q) : byte_idx_q;
    sel_byte = word_q[{lane, 3'b000} +: 8];
  end

  // State register and datapath registers; reset aborts any dump in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_ISSUE;
      S_ISSUE:    state_d = S_CAPTURE;
      S_CAPTURE:  state_d = S_SEND;
      S_SEND:     if (!tx_busy) state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (tx_busy) state_d = S_WAIT_TX;
      S_WAIT_TX:  if (!tx_busy) state_d = (byte_idx_q == 2'd3) ? S_NEXT : S_SEND;
      S_NEXT:     state_d = (addr_q == last_q) ? S_DONE : S_ISSUE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath updates; tx_data and tx_start are registered together so the
  // strobe and its byte leave the block on the same cycle, glitch-free.
  always_comb begin
    addr_d     = addr_q;
    last_d     = last_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = first_addr;
          last_d = last_addr;
        end
      end
      S_CAPTURE: begin
        word_d     = mem_data_read;
        byte_idx_d = 2'd0;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = sel_byte;
        end
      end
      S_WAIT_TX: begin
        if (!tx_busy && byte_idx_q != 2'd3) byte_idx_d = byte_idx_q + 2'd1;
      end
      S_NEXT: begin
        if (addr_q != last_q) addr_d = addr_q + ADDR_ONE;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state and registers.
  always_comb begin
    mem_address = addr_q;
    mem_write   = 1'b0;
    tx_data     = tx_data_q;
    tx_start    = tx_start_q;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
  end

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the data memory (1024 x 32-bit words).
REQ-002 Parameter MSB_FIRST, default 1; 1 = byte 3 (bits 31:24) sent first, 0 = byte 0 (bits 7:0) sent first.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 first_addr  input  ADDR_W  first word address; captured on accepted start.
REQ-007 last_addr  input  ADDR_W  last word address, inclusive; captured on accepted start.
REQ-008 mem_address  output  ADDR_W  registered word address to the data memory.
REQ-009 mem_write  output  1  memory write enable; constant 0.
REQ-010 mem_data_read  input  32  memory read data; the memory updates it on the falling clock edge after mem_address changes.
REQ-011 tx_data  output  8  byte presented to the UART transmitter.
REQ-012 tx_start  output  1  one-cycle strobe requesting transmission of tx_data.
REQ-013 tx_busy  input  1  UART transmitter busy; rises after an accepted tx_start and falls when the byte is sent.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the last byte of last_addr completes.

Function
REQ-016 FSM states: IDLE, ISSUE, CAPTURE, SEND, WAIT_ACK, WAIT_TX, NEXT, DONE.
REQ-017 IDLE, start=1: latch first_addr into cur_addr, latch last_addr, set mem_address=first_addr, go ISSUE.
REQ-018 ISSUE: hold for exactly one cycle so the memory can return data on the falling edge; go CAPTURE.
REQ-019 CAPTURE: register mem_data_read into a 32-bit word buffer; clear byte_idx to 0; go SEND.
REQ-020 SEND, tx_busy=0: drive tx_data with the selected byte and tx_start=1 for exactly one cycle; go WAIT_ACK.
REQ-021 SEND, tx_busy=1: stay in SEND with tx_start=0.
REQ-022 WAIT_ACK: wait for tx_busy=1, then go WAIT_TX; tx_start stays 0.
REQ-023 WAIT_TX: wait for tx_busy=0; if byte_idx=3 go NEXT, else increment byte_idx and go SEND.
REQ-024 NEXT: if cur_addr=last_addr go DONE; otherwise increment cur_addr modulo 2^ADDR_W, update mem_address, and go ISSUE.
REQ-025 DONE: assert done for one cycle; go IDLE.
REQ-026 Byte selection: with MSB_FIRST=1, byte_idx k selects bits [31-8k : 24-8k]; with MSB_FIRST=0 it selects bits [8k+7 : 8k].
REQ-027 Wrap-around: if first_addr > last_addr, addresses increment through 2^ADDR_W-1 to 0 and continue up to last_addr.
REQ-028 first_addr = last_addr: exactly one word (4 bytes) is sent.
REQ-029 start while busy=1 is ignored; first_addr and last_addr changes after the accepted start have no effect on the dump in progress.
REQ-030 tx_data holds its value from SEND until the next SEND; tx_data is don't-care only in IDLE.
REQ-031 Each word's memory read takes 2 cycles (ISSUE, CAPTURE), and no read occurs while a byte is in flight.
REQ-032 mem_write is never asserted, in any state or during reset.

Reset
REQ-033 reset=0 asynchronously forces IDLE, and sets mem_address=0, tx_data=0, tx_start=0, busy=0, done=0, byte_idx=0, word buffer=0.
REQ-034 reset asserted mid-dump aborts it immediately, with no done pulse; after release the block waits in IDLE for a new start.

Verification
REQ-035 Memory model word[i]=i, MSB_FIRST=1, first=5, last=5, UART model busy 10 cycles -> bytes 00,00,00,05 in order, then done pulses once, and busy falls the cycle after done.
REQ-036 first=1022, last=1, word[i]=i -> 16 bytes for words 1022, 1023, 0, 1 in address order, then one done pulse.
REQ-037 tx_busy held high 20 cycles before the first SEND -> tx_start is not asserted until tx_busy=0, and exactly one tx_start per byte.
REQ-038 start pulsed again while busy, with different first/last -> ignored; the byte stream matches the original range.
REQ-039 reset pulsed low after the second byte of a 3-word dump -> all outputs reach their reset values immediately, no done pulse; a following start=1 with first=0, last=0 produces 4 bytes.
REQ-040 MSB_FIRST=0, word[7]=32'h11223344, first=last=7 -> bytes 44,33,22,11; mem_write=0 throughout.
